// File: rtl/fan_ctrl_pkg.sv
// Shared constants, state encodings and lookup helpers for the fan duty controller.
// Segment table drives the manual RPM mapping; band tables drive the auto mode.
package fan_ctrl_pkg;

  localparam int SEG_B0 = 500;
  localparam int SEG_B1 = 1000;
  localparam int SEG_B2 = 1950;
  localparam int SEG_B3 = 3800;

  localparam int SEG_OFF0 = 0;
  localparam int SEG_OFF1 = 30;
  localparam int SEG_OFF2 = 50;

  localparam int SEG_SLP0 = 25;
  localparam int SEG_SLP1 = 32;
  localparam int SEG_SLP2 = 37;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_LOAD
  } man_st_e;

  typedef enum logic [2:0] {
    B0, B1, B2, B3, B4, B5
  } band_e;

  // B5 has no upper edge; the caller never asks for it.
  function automatic int band_upper(band_e b);
    case (b)
      B0:      return 30;
      B1:      return 40;
      B2:      return 50;
      B3:      return 60;
      B4:      return 70;
      default: return 1000;
    endcase
  endfunction

  function automatic int band_duty(band_e b);
    case (b)
      B0:      return 0;
      B1:      return 20;
      B2:      return 40;
      B3:      return 60;
      B4:      return 80;
      default: return 100;
    endcase
  endfunction

endpackage

// File: rtl/fan_duty_ramp_ctrl_seq_div.sv
// Unsigned restoring divider, one quotient bit per clock.
// done pulses for one cycle once the quotient is final; quotient holds afterwards.
module seq_div #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_run;
  logic             r_done;

  logic [WIDTH:0]   w_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;

  assign w_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_ge  = (w_sh >= {1'b0, r_dvs});
  // Remainder after a successful subtract is below the divisor, so it fits.
  assign w_sub = w_sh[WIDTH-1:0] - r_dvs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else if (start) begin
      r_rem  <= '0;
      r_quo  <= dividend;
      r_dvs  <= divisor;
      r_cnt  <= CW'(WIDTH);
      r_run  <= 1'b1;
      r_done <= 1'b0;
    end else if (r_run) begin
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
      r_rem <= w_ge ? w_sub : w_sh[WIDTH-1:0];
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign quotient = r_quo;
  assign done     = r_done;

endmodule

// File: rtl/fan_duty_ramp_ctrl.sv
// Fan duty controller: manual RPM or auto temperature band to a ramped PWM duty.
// Define FAN_KICKSTART_EN to add a full-duty kick when spinning up from zero.
module fan_duty_ramp_ctrl
  import fan_ctrl_pkg::*;
#(
  parameter int SPEED_W     = 12,
  parameter int TEMP_W      = 8,
  parameter int DUTY_W      = 7,
  parameter int DUTY_MAX    = 100,
  parameter int HYST        = 2,
  parameter int RAMP_DIV    = 50000,
  parameter int KICK_CYCLES = 25000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [SPEED_W:0]  unpack_data,
  input  logic              unpack_valid,
  input  logic [TEMP_W-1:0] temp_data,
  output logic [DUTY_W-1:0] duty_data,
  output logic [DUTY_W-1:0] duty_target,
  output logic              busy,
  output logic              at_target
);

  localparam int RCW = $clog2(RAMP_DIV + 1);

  localparam logic [SPEED_W-1:0] L0 = SPEED_W'(SEG_B0);
  localparam logic [SPEED_W-1:0] L1 = SPEED_W'(SEG_B1);
  localparam logic [SPEED_W-1:0] L2 = SPEED_W'(SEG_B2);
  localparam logic [SPEED_W-1:0] L3 = SPEED_W'(SEG_B3);
  localparam logic [DUTY_W-1:0]  DMAX = DUTY_W'(DUTY_MAX);

  man_st_e r_st, w_st_nxt;
  band_e   r_band, w_band_nxt;

  logic               r_mode;
  logic               r_busy;
  logic               r_pend_v;
  logic [SPEED_W-1:0] r_pend_spd;
  logic               r_nodiv;
  logic [DUTY_W-1:0]  r_off;
  logic [DUTY_W-1:0]  r_tgt;
  logic [DUTY_W-1:0]  r_duty;
  logic               r_at;
  logic [RCW-1:0]     r_rcnt;

  logic               w_new_man;
  logic               w_go;
  logic [SPEED_W-1:0] w_spd;
  logic [SPEED_W-1:0] w_base;
  logic [SPEED_W-1:0] w_slope;
  logic [SPEED_W-1:0] w_dvd;
  logic [DUTY_W-1:0]  w_off;
  logic               w_nodiv;
  logic               w_div_start;
  logic               w_div_done;
  logic [SPEED_W-1:0] w_quo;
  logic [SPEED_W:0]   w_sum;
  logic [DUTY_W-1:0]  w_load;
  logic               w_busy_nxt;
  logic [DUTY_W-1:0]  w_tgt_nxt;
  logic [DUTY_W-1:0]  w_duty_nxt;
  logic               w_step;

  assign w_new_man = unpack_valid & unpack_data[SPEED_W];
  assign w_spd     = w_new_man ? unpack_data[SPEED_W-1:0]
                               : r_pend_spd;
  assign w_go      = (r_st == S_IDLE) & (w_new_man | r_pend_v);

  always_comb begin
    w_nodiv = 1'b0;
    w_off   = '0;
    w_base  = '0;
    w_slope = SPEED_W'(1);
    unique case (1'b1)
      (w_spd < L0): begin
        w_nodiv = 1'b1;
      end
      (w_spd >= L0 && w_spd < L1): begin
        w_base  = L0;
        w_slope = SPEED_W'(SEG_SLP0);
        w_off   = DUTY_W'(SEG_OFF0);
      end
      (w_spd >= L1 && w_spd < L2): begin
        w_base  = L1;
        w_slope = SPEED_W'(SEG_SLP1);
        w_off   = DUTY_W'(SEG_OFF1);
      end
      (w_spd >= L2 && w_spd <= L3): begin
        w_base  = L2;
        w_slope = SPEED_W'(SEG_SLP2);
        w_off   = DUTY_W'(SEG_OFF2);
      end
      default: begin
        w_nodiv = 1'b1;
        w_off   = DMAX;
      end
    endcase
  end

  assign w_dvd       = w_spd - w_base;
  assign w_div_start = w_go & ~w_nodiv;

  seq_div #(
    .WIDTH(SPEED_W)
  ) u_div (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .start    (w_div_start),
    .dividend (w_dvd),
    .divisor  (w_slope),
    .quotient (w_quo),
    .done     (w_div_done)
  );

  assign w_sum  = {1'b0, w_quo} + (SPEED_W+1)'(r_off);
  assign w_load = r_nodiv ? r_off :
                  (w_sum > (SPEED_W+1)'(DUTY_MAX)) ? DMAX :
                  w_sum[DUTY_W-1:0];

  always_comb begin
    w_st_nxt = r_st;
    unique case (r_st)
      S_IDLE: if (w_go) w_st_nxt = w_nodiv ? S_LOAD : S_DIV;
      S_DIV:  if (w_div_done) w_st_nxt = S_LOAD;
      S_LOAD: w_st_nxt = S_IDLE;
      default: w_st_nxt = S_IDLE;
    endcase
  end

  // Table-only results pass through LOAD without ever raising busy.
  assign w_busy_nxt = (w_st_nxt == S_DIV) |
                      ((w_st_nxt == S_LOAD) & (r_st == S_DIV));

  always_comb begin
    w_band_nxt = r_band;
    if (r_band != B5 &&
        int'(temp_data) > band_upper(r_band))
      w_band_nxt = band_e'(r_band + 3'd1);
    else if (r_band != B0 &&
             int'(temp_data) <=
             band_upper(band_e'(r_band - 3'd1)) - HYST)
      w_band_nxt = band_e'(r_band - 3'd1);
  end

  // A divide landing after a switch to auto is dropped here.
  always_comb begin
    w_tgt_nxt = r_tgt;
    if (!r_mode)
      w_tgt_nxt = DUTY_W'(band_duty(r_band));
    else if (r_st == S_LOAD)
      w_tgt_nxt = w_load;
  end

  assign w_step = (r_rcnt == RCW'(RAMP_DIV - 1));

`ifdef FAN_KICKSTART_EN
  localparam int KCW = $clog2(KICK_CYCLES + 1);
  logic           r_kick, w_kick_nxt;
  logic [KCW-1:0] r_kcnt, w_kcnt_nxt;
`endif

  always_comb begin
    w_duty_nxt = r_duty;
    if (w_step) begin
      if (r_duty < r_tgt)
        w_duty_nxt = r_duty + DUTY_W'(1);
      else if (r_duty > r_tgt)
        w_duty_nxt = r_duty - DUTY_W'(1);
    end
`ifdef FAN_KICKSTART_EN
    w_kick_nxt = r_kick;
    w_kcnt_nxt = r_kcnt;
    if (r_kick) begin
      w_kcnt_nxt = r_kcnt + KCW'(1);
      w_duty_nxt = DMAX;
      if (r_tgt == '0) begin
        w_kick_nxt = 1'b0;
        w_duty_nxt = '0;
      end else if (r_kcnt == KCW'(KICK_CYCLES - 1)) begin
        w_kick_nxt = 1'b0;
        w_duty_nxt = r_tgt;
      end
    end else if (r_duty == '0 && r_tgt != '0) begin
      w_kick_nxt = 1'b1;
      w_kcnt_nxt = '0;
      w_duty_nxt = DMAX;
    end
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_st       <= S_IDLE;
      r_band     <= B0;
      r_mode     <= 1'b0;
      r_busy     <= 1'b0;
      r_pend_v   <= 1'b0;
      r_pend_spd <= '0;
      r_nodiv    <= 1'b0;
      r_off      <= '0;
      r_tgt      <= '0;
      r_duty     <= '0;
      r_at       <= 1'b1;
      r_rcnt     <= '0;
    end else begin
      r_st   <= w_st_nxt;
      r_band <= w_band_nxt;
      r_busy <= w_busy_nxt;
      r_tgt  <= w_tgt_nxt;
      r_duty <= w_duty_nxt;
      r_at   <= (w_duty_nxt == w_tgt_nxt);
      r_rcnt <= w_step ? '0 : r_rcnt + RCW'(1);
      if (unpack_valid)
        r_mode <= unpack_data[SPEED_W];
      if (w_go) begin
        r_nodiv  <= w_nodiv;
        r_off    <= w_off;
        r_pend_v <= 1'b0;
      end else if (w_new_man) begin
        r_pend_v   <= 1'b1;
        r_pend_spd <= unpack_data[SPEED_W-1:0];
      end
    end
  end

`ifdef FAN_KICKSTART_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_kick <= 1'b0;
      r_kcnt <= '0;
    end else begin
      r_kick <= w_kick_nxt;
      r_kcnt <= w_kcnt_nxt;
    end
  end
`endif

  assign duty_data   = r_duty;
  assign duty_target = r_tgt;
  assign busy        = r_busy;
  assign at_target   = r_at;

endmodule
